// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: ALU operation
// codes, sequencer states, major opcodes and datapath select values.
package alu_seq_pkg;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_SLL   = 5'd2;
   localparam logic [4:0] ALU_SLT   = 5'd3;
   localparam logic [4:0] ALU_SLTU  = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_OR    = 5'd8;
   localparam logic [4:0] ALU_AND   = 5'd9;
   localparam logic [4:0] ALU_PASSB = 5'd10;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_TRAP
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;

   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_RS1   = 2'd1;
   localparam logic [1:0] SRC_A_OLDPC = 2'd2;
   localparam logic [1:0] SRC_A_ZERO  = 2'd3;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   localparam logic       ADDR_PC     = 1'b0;
   localparam logic       ADDR_ALUOUT = 1'b1;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder: maps opcode, funct3 and funct7[5] onto
// the ALU operation used in EXECUTE, and flags encodings the sequencer does
// not implement.
module alu_op_decode
   import alu_seq_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [4:0] alu_op,
   output logic       illegal
);

   // Select the ALU operation per instruction class and spot unknown encodings
   always_comb begin
      alu_op  = ALU_ADD;
      illegal = 1'b0;
      case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            case (funct3)
               3'd0:    alu_op = (funct7_5 && opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
               3'd1:    alu_op = ALU_SLL;
               3'd2:    alu_op = ALU_SLT;
               3'd3:    alu_op = ALU_SLTU;
               3'd4:    alu_op = ALU_XOR;
               3'd5:    alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
               3'd6:    alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
            // funct7[5] is meaningful only for SUB/SRA/SRAI; on OP-IMM the
            // other funct3 values carry immediate bits there, except SLLI
            if (funct3 == 3'd1 && funct7_5)
               illegal = 1'b1;
            if (opcode == OPC_OP && funct7_5 && funct3 != 3'd0 && funct3 != 3'd5)
               illegal = 1'b1;
         end
         OPC_LUI:   alu_op = ALU_PASSB;
         OPC_AUIPC: alu_op = ALU_ADD;
         OPC_LOAD:  illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
         OPC_STORE: illegal = (funct3 > 3'd2);
         OPC_JAL:   alu_op = ALU_ADD;
         OPC_JALR:  illegal = (funct3 != 3'd0);
         OPC_BRANCH: begin
            case (funct3)
               3'd0, 3'd1: alu_op = ALU_SUB;
               3'd4, 3'd5: alu_op = ALU_SLT;
               3'd6, 3'd7: alu_op = ALU_SLTU;
               default:    illegal = 1'b1;
            endcase
         end
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// All outputs are decoded from the state and the latched instruction; none is
// registered. While rst_n is low every output is forced to zero.
// Build option ALU_SEQ_TRAP_EN: unknown encodings and fetch timeouts
// (FETCH_TIMEOUT cycles, 0 = never) enter a sticky TRAP state. Without it,
// unknown encodings retire as a NOP and trap is tied low.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int FETCH_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   input  logic        alu_lsb,
   input  logic        mem_ready,
   output logic [4:0]  alu_op,
   output logic [1:0]  src_a_sel,
   output logic [1:0]  src_b_sel,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        trap
);

   state_t     state;
   state_t     state_nxt;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       rd_nz;
   logic [4:0] dec_op;
   logic       dec_illegal;
   logic       br_taken;
   logic       timeout;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign rd_nz        = (instr[11:7] != 5'd0);
   assign unused_instr = ^{instr[31], instr[29:15]};

   alu_op_decode u_decode (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (instr[30]),
      .alu_op   (dec_op),
      .illegal  (dec_illegal)
   );

   // Equality branches test alu_zero (SUB); ordered branches test the SLT/SLTU
   // result bit. funct3[0] inverts the sense (BNE/BGE/BGEU).
   assign br_taken = (funct3[2] ? alu_lsb : alu_zero) ^ funct3[0];

`ifdef ALU_SEQ_TRAP_EN
   localparam state_t BAD_NXT = S_TRAP;
   localparam int     CNT_W   = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

   logic [CNT_W-1:0] wait_cnt;

   // Count consecutive FETCH cycles that memory has left unanswered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (state == S_FETCH && !mem_ready)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end

   assign timeout = (FETCH_TIMEOUT != 0) && (wait_cnt == CNT_W'(FETCH_TIMEOUT - 1));
   assign trap    = (state == S_TRAP);
`else
   localparam state_t BAD_NXT = S_FETCH;

   logic unused_cfg;

   assign unused_cfg = (FETCH_TIMEOUT != 0);
   assign timeout    = 1'b0;
   assign trap       = 1'b0;
`endif

   // State register; reset abandons any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_FETCH;
      else
         state <= state_nxt;
   end

   // Next-state selection and state/instruction-decoded datapath controls
   always_comb begin
      state_nxt = state;
      alu_op    = ALU_ADD;
      src_a_sel = SRC_A_PC;
      src_b_sel = SRC_B_RS2;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = ADDR_PC;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      if (rst_n) begin
         case (state)
            S_FETCH: begin
               mem_req   = 1'b1;
               src_b_sel = SRC_B_FOUR;
               if (mem_ready) begin
                  ir_we     = 1'b1;
                  pc_we     = 1'b1;
                  state_nxt = S_DECODE;
               end else if (timeout) begin
                  state_nxt = S_TRAP;
               end
            end
            S_DECODE: begin
               src_a_sel = SRC_A_OLDPC;
               src_b_sel = SRC_B_IMM;
               state_nxt = dec_illegal ? BAD_NXT : S_EXECUTE;
            end
            S_EXECUTE: begin
               alu_op    = dec_op;
               state_nxt = S_FETCH;
               case (opcode)
                  OPC_OP: begin
                     src_a_sel = SRC_A_RS1;
                     state_nxt = S_WRITEBACK;
                  end
                  OPC_OP_IMM: begin
                     src_a_sel = SRC_A_RS1;
                     src_b_sel = SRC_B_IMM;
                     state_nxt = S_WRITEBACK;
                  end
                  OPC_LUI: begin
                     src_a_sel = SRC_A_ZERO;
                     src_b_sel = SRC_B_IMM;
                     state_nxt = S_WRITEBACK;
                  end
                  OPC_AUIPC: begin
                     src_a_sel = SRC_A_OLDPC;
                     src_b_sel = SRC_B_IMM;
                     state_nxt = S_WRITEBACK;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     src_a_sel = SRC_A_RS1;
                     src_b_sel = SRC_B_IMM;
                     state_nxt = S_MEMORY;
                  end
                  OPC_BRANCH: begin
                     src_a_sel = SRC_A_RS1;
                     pc_we     = br_taken;
                  end
                  OPC_JAL: begin
                     src_a_sel = SRC_A_OLDPC;
                     src_b_sel = SRC_B_IMM;
                     pc_we     = 1'b1;
                     rf_we     = rd_nz;
                     wb_sel    = WB_PC4;
                  end
                  OPC_JALR: begin
                     src_a_sel = SRC_A_RS1;
                     src_b_sel = SRC_B_IMM;
                     pc_we     = 1'b1;
                     rf_we     = rd_nz;
                     wb_sel    = WB_PC4;
                  end
                  default: state_nxt = S_FETCH;
               endcase
            end
            S_MEMORY: begin
               mem_req  = 1'b1;
               addr_sel = ADDR_ALUOUT;
               mem_we   = (opcode == OPC_STORE);
               if (mem_ready)
                  state_nxt = (opcode == OPC_STORE) ? S_FETCH : S_WRITEBACK;
            end
            S_WRITEBACK: begin
               rf_we     = rd_nz;
               wb_sel    = (opcode == OPC_LOAD) ? WB_MEM : WB_ALU;
               state_nxt = S_FETCH;
            end
            default: state_nxt = S_TRAP;
         endcase
      end
   end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle control sequencer that drives the 5-bit ALU operation code and operand/write-back selects for the multicycle RV32I datapath. It fetches through a req/ready memory handshake, decodes the latched instruction, and walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It sits between instruction memory and the datapath, and is the only producer of `alu_op`.

## Interface
- `FETCH_TIMEOUT`, default 0: cycles to wait for `mem_ready` before trapping; 0 means wait forever. Only used with `ALU_SEQ_TRAP_EN`.
- `clk` (in, 1): single clock, rising edge.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `instr` (in, 32): instruction register contents, valid from DECODE onward.
- `alu_zero` (in, 1): ALUResult == 0.
- `alu_lsb` (in, 1): ALUResult[0].
- `mem_ready` (in, 1): memory completes the current request this cycle.
- `alu_op` (out, 5): 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `src_a_sel` (out, 2): 0 PC, 1 rs1, 2 oldPC, 3 zero.
- `src_b_sel` (out, 2): 0 rs2, 1 imm, 2 const 4.
- `mem_req`, `mem_we`, `addr_sel` (out, 1 each): addr_sel 0 selects PC, 1 selects ALUOut.
- `ir_we`, `pc_we`, `rf_we` (out, 1 each).
- `wb_sel` (out, 2): 0 ALUOut, 1 mem data, 2 PC+4.
- `trap` (out, 1): sticky illegal/timeout flag.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH: mem_req=1, addr_sel=0, ALU computes PC+4 (a=PC, b=4, ADD). On mem_ready: ir_we=1, pc_we=1, go to DECODE. Otherwise hold every output.
- DECODE: ALU computes oldPC+imm (branch/JAL target) into ALUOut. Go to EXECUTE.
- EXECUTE by opcode:
  - R-type/OP-IMM: alu_op from funct3 and funct7[5] (SRAI/SRA use funct7[5]; SUB only for R-type).
  - LUI: PASSB with b=imm.
  - AUIPC: a=oldPC, b=imm.
  - Load/store: ADD rs1+imm, then MEMORY.
  - Branch: BEQ/BNE use SUB and alu_zero; BLT/BGE use SLT and alu_lsb; BLTU/BGEU use SLTU and alu_lsb. Taken: pc_we=1 loading ALUOut. Then FETCH.
  - JAL: pc_we from ALUOut, rf_we with wb_sel=2, then FETCH.
  - JALR: ADD rs1+imm, pc_we with LSB cleared, wb_sel=2, then FETCH.
  - ALU ops, LUI and AUIPC go to WRITEBACK.
- MEMORY: mem_req=1, addr_sel=1, mem_we=1 for stores, held until mem_ready. Stores then go to FETCH; loads go to WRITEBACK.
- WRITEBACK: rf_we=1 (suppressed when rd==0), wb_sel 0 or 1. Go to FETCH.
- Reset values: state FETCH, alu_op 0, every enable 0, trap 0, selects 0. Outputs are a function of state and instr only (Moore + decode); no output is registered.
- Reset asserted mid-instruction: abandon it immediately; resume at FETCH with no partial writes.

## Timing
- Latency with zero-wait memory (mem_ready=1 in the request cycle): ALU/LUI/AUIPC 4 cycles, load 5, store 4, branch/JAL/JALR 3.
- Each wait cycle adds one cycle.
- mem_req is never dropped before mem_ready.
- mem_ready while mem_req=0 is ignored.

## Configuration
- `ALU_SEQ_TRAP_EN` defined:
  - Unknown opcode or funct, or FETCH_TIMEOUT expiry, goes to TRAP.
  - TRAP holds all enables 0 and trap=1 until reset.
- Undefined: unknown encodings execute as NOP (DECODE then FETCH, no writes). trap is tied 0.

## Structure
- Shared package `alu_seq_pkg` holds:
  - alu_op localparams matching the ALU encoding.
  - state enum.
  - opcode constants.
  - select encodings.
- One sub-module, `alu_op_decode` (combinational): maps opcode, funct3 and funct7[5] to alu_op and an illegal flag.

## Test plan
- ADD x3,x1,x2 (0x002081B3), mem_ready tied 1: alu_op 0, then 0, then 0. rf_we pulses in cycle 4 only. wb_sel=0.
- SRAI (funct7=0x20, funct3=5, opcode 0x13): alu_op=7 in EXECUTE. SUB with the same funct7 but opcode 0x13 decodes as ADDI (alu_op 0).
- BLTU, alu_lsb=1: alu_op=4, pc_we=1 in EXECUTE, total 3 cycles. With alu_lsb=0: pc_we=0.
- LW, mem_ready low for 3 cycles in MEMORY: mem_req held 4 cycles. Load completes in 8 cycles with rf_we and wb_sel=1.
- rst_n pulled low during MEMORY of SW: outputs go to 0 the same cycle, state FETCH after release, no mem_we.
- Opcode 0x7F: with trap enabled, trap=1 permanently. Without, returns to FETCH in 2 cycles, no rf_we.
